// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter between video scan-out and soft CPU
// Video wins every slot unless a CPU request has lost STARVE_LIM slots in a row.
module vram_arbiter #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8,
  parameter int STARVE_LIM = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_valid,
  output logic              vid_drop,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_CPU_RD, TAG_CPU_WR} tag_t;

  localparam logic [7:0] LIM = 8'(STARVE_LIM);

  logic [7:0] wait_cnt;
  logic       cpu_busy;
  tag_t       tag1;
  tag_t       tag2;

  logic cpu_eligible;
  logic force_cpu;
  logic grant_cpu;
  logic grant_vid;
  logic tag2_cpu;

  assign cpu_eligible = cpu_req & ~cpu_busy;
  assign force_cpu    = cpu_eligible & (wait_cnt == LIM);
  assign grant_cpu    = force_cpu | (cpu_eligible & ~vid_req);
  assign grant_vid    = vid_req & ~force_cpu;
  assign tag2_cpu     = (tag2 == TAG_CPU_RD) || (tag2 == TAG_CPU_WR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt  <= '0;
      cpu_busy  <= 1'b0;
      tag1      <= TAG_NONE;
      tag2      <= TAG_NONE;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      vid_drop  <= 1'b0;
      vid_valid <= 1'b0;
      vid_rdata <= '0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      mem_en   <= grant_cpu | grant_vid;
      mem_we   <= grant_cpu & cpu_we;
      vid_drop <= force_cpu & vid_req;

      // Idle slots leave address and write data parked on the last grant.
      if (grant_cpu) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end else if (grant_vid) begin
        mem_addr <= vid_addr;
      end

      // A non-granted eligible CPU request can only mean video took the slot.
      if (grant_cpu || !cpu_eligible) begin
        wait_cnt <= '0;
      end else if (wait_cnt != LIM) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if (grant_cpu) begin
        tag1 <= cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
      end else if (grant_vid) begin
        tag1 <= TAG_VID;
      end else begin
        tag1 <= TAG_NONE;
      end
      tag2 <= tag1;

      vid_valid <= (tag2 == TAG_VID);
      cpu_ack   <= tag2_cpu;
      if (tag2 == TAG_VID) begin
        vid_rdata <= mem_rdata;
      end
      if (tag2 == TAG_CPU_RD) begin
        cpu_rdata <= mem_rdata;
      end

      if (grant_cpu) begin
        cpu_busy <= 1'b1;
      end else if (tag2_cpu) begin
        cpu_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter
// Slot-by-slot reference model with a future-event table and a shadow copy of VRAM.
module tb_vram_arbiter;

  localparam int AW  = 13;
  localparam int DW  = 8;
  localparam int LIM = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [DW-1:0] vid_rdata;
  logic          vid_valid;
  logic          vid_drop;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata),
    .vid_valid(vid_valid), .vid_drop(vid_drop),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [7:0] init_val(input logic [12:0] a);
    logic [7:0] p;
    p = a[7:0] * 8'd37;
    return (p + {3'b000, a[12:8]}) ^ 8'hE5;
  endfunction

  // Synchronous single-port RAM; unwritten locations return init_val.
  bit [7:0] ram [0:(1<<AW)-1];
  bit       written [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= written[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
      if (mem_we) begin
        ram[mem_addr]     <= mem_wdata;
        written[mem_addr] <= 1'b1;
      end
    end
  end

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;
  int last_cg;
  int lost;
  int n_drop_obs;
  int n_vv_obs;

  logic [7:0] shadow [0:(1<<AW)-1];
  bit         ev_vid [8];
  bit         ev_cpu [8];
  bit         ev_wr  [8];
  logic [7:0] ev_data[8];

  logic          e_en, e_we, e_drop, e_vvalid, e_ack;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_vrdata, e_crdata;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("mem_en",    16'(mem_en),    16'(e_en));
    chk("mem_we",    16'(mem_we),    16'(e_we));
    chk("mem_addr",  16'(mem_addr),  16'(e_addr));
    chk("mem_wdata", 16'(mem_wdata), 16'(e_wdata));
    chk("vid_drop",  16'(vid_drop),  16'(e_drop));
    chk("vid_valid", 16'(vid_valid), 16'(e_vvalid));
    chk("vid_rdata", 16'(vid_rdata), 16'(e_vrdata));
    chk("cpu_ack",   16'(cpu_ack),   16'(e_ack));
    chk("cpu_rdata", 16'(cpu_rdata), 16'(e_crdata));
  endtask

  task automatic model_reset();
    last_cg = -1000;
    lost    = 0;
    for (int i = 0; i < 8; i++) begin
      ev_vid[i] = 1'b0;
      ev_cpu[i] = 1'b0;
      ev_wr[i]  = 1'b0;
      ev_data[i] = '0;
    end
    e_en = 1'b0; e_we = 1'b0; e_drop = 1'b0; e_vvalid = 1'b0; e_ack = 1'b0;
    e_addr = '0; e_wdata = '0; e_vrdata = '0; e_crdata = '0;
  endtask

  // Predict the slot decided at the coming edge, advance one clock, compare.
  task automatic step();
    bit elig, cw, vw;
    int k, s;
    k = cyc;
    elig = cpu_req && (k - last_cg > 2);
    if (elig && lost == LIM) begin
      cw = 1'b1; vw = 1'b0;
    end else if (vid_req) begin
      cw = 1'b0; vw = 1'b1;
    end else begin
      cw = elig; vw = 1'b0;
    end
    e_drop = cw && vid_req;
    e_en   = cw || vw;
    e_we   = cw && cpu_we;
    if (vw) e_addr = vid_addr;
    if (cw) begin
      e_addr  = cpu_addr;
      e_wdata = cpu_wdata;
    end
    if (!elig || cw) lost = 0;
    else if (lost < LIM) lost++;
    s = (k + 2) % 8;
    if (vw) begin
      ev_vid[s]  = 1'b1;
      ev_data[s] = shadow[vid_addr];
    end
    if (cw) begin
      ev_cpu[s]  = 1'b1;
      ev_wr[s]   = cpu_we;
      ev_data[s] = shadow[cpu_addr];
      last_cg    = k;
      if (cpu_we) shadow[cpu_addr] = cpu_wdata;
    end
    s = k % 8;
    e_vvalid = ev_vid[s];
    e_ack    = ev_cpu[s];
    if (ev_vid[s]) e_vrdata = ev_data[s];
    if (ev_cpu[s] && !ev_wr[s]) e_crdata = ev_data[s];
    ev_vid[s] = 1'b0;
    ev_cpu[s] = 1'b0;
    ev_wr[s]  = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
    if (vid_drop) n_drop_obs++;
    if (vid_valid) n_vv_obs++;
  endtask

  task automatic run_until_ack(output int steps);
    steps = 0;
    do begin
      step();
      steps++;
    end while (!e_ack && steps < 20);
    if (!e_ack) chk("ack_timeout", 16'(steps), 16'd0);
  endtask

  task automatic hold_reset(input int cycles);
    reset = 1'b0;
    model_reset();
    #1;
    check_outputs();
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      check_outputs();
    end
    reset = 1'b1;
  endtask

  initial begin
    int n, ack_at;
    for (int a = 0; a < (1 << AW); a++) shadow[a] = init_val(13'(a));
    model_reset();

    // Reset held from time zero, then idle after release.
    repeat (2) @(posedge clk);
    #1;
    hold_reset(2);
    repeat (6) step();

    // Single video read of a known location.
    vid_req = 1'b1; vid_addr = 13'h040;
    step();
    chk("vid_grant_addr", 16'(mem_addr), 16'h0040);
    vid_req = 1'b0;
    step();
    step();
    chk("vid_a5", 16'(vid_rdata), 16'h00A5);
    step();

    // CPU write then read back, no video traffic.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h100; cpu_wdata = 8'h3C;
    run_until_ack(n);
    chk("wr_latency", 16'(n), 16'd3);
    cpu_we = 1'b0;
    run_until_ack(n);
    chk("rd_latency", 16'(n), 16'd3);
    cpu_req = 1'b0;
    chk("rd_3c", 16'(cpu_rdata), 16'h003C);
    step();

    // Starvation: video every cycle against a held CPU read.
    n_drop_obs = 0;
    ack_at = -1;
    vid_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h010;
    for (int i = 0; i < 14; i++) begin
      vid_addr = 13'($urandom_range(0, 8191));
      step();
      if (cpu_ack) ack_at = i;
      if (e_ack) cpu_req = 1'b0;
    end
    vid_req = 1'b0;
    repeat (3) step();
    chk("starve_drops", 16'(n_drop_obs), 16'd1);
    chk("starve_ack_at", 16'(ack_at), 16'd10);

    // Video at clk/2 with a continuous CPU read stream.
    n_drop_obs = 0;
    n_vv_obs = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'($urandom_range(0, 63));
    for (int i = 0; i < 40; i++) begin
      vid_req  = (i % 2 == 0);
      vid_addr = 13'($urandom_range(0, 8191));
      step();
      if (e_ack) cpu_addr = 13'($urandom_range(0, 63));
    end
    vid_req = 1'b0;
    run_until_ack(n);
    cpu_req = 1'b0;
    repeat (2) step();
    chk("half_rate_drops", 16'(n_drop_obs), 16'd0);
    chk("half_rate_valids", 16'(n_vv_obs), 16'd20);

    // Reset lands one cycle after a CPU read grant.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h020;
    step();
    step();
    hold_reset(2);
    step();
    chk("rst_regrant_en", 16'(mem_en), 16'd1);
    chk("rst_regrant_addr", 16'(mem_addr), 16'h0020);
    run_until_ack(n);
    cpu_req = 1'b0;
    step();

    // Randomized traffic with rising video density.
    for (int i = 0; i < 500; i++) begin
      vid_req  = ($urandom_range(0, 3) < (i / 125) + 1);
      vid_addr = 13'($urandom_range(0, 31));
      if (!cpu_req && $urandom_range(0, 1) == 1) begin
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 13'($urandom_range(0, 31));
        cpu_wdata = 8'($urandom_range(0, 255));
      end
      step();
      if (e_ack) begin
        if ($urandom_range(0, 1) == 1) begin
          cpu_we    = 1'($urandom_range(0, 1));
          cpu_addr  = 13'($urandom_range(0, 31));
          cpu_wdata = 8'($urandom_range(0, 255));
        end else begin
          cpu_req = 1'b0;
        end
      end
    end
    vid_req = 1'b0;
    if (cpu_req) run_until_ack(n);
    cpu_req = 1'b0;
    repeat (3) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
